// File: rtl/auth_pkg.sv
// auth_pkg: state encoding and ASCII defaults shared by the authorization controller.
package auth_pkg;
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    KEY          = 3'd1,
    CONNECTED    = 3'd2,
    DISCONNECTED = 3'd3,
    LOCKOUT      = 3'd4
  } auth_state_t;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_S = 8'h53;
endpackage

// File: rtl/auth_timer.sv
// auth_timer: loadable down-counter that holds at zero; serves both link timeout and lockout.
module auth_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  assign zero = cnt_q == '0;
endmodule

// File: rtl/auth_ctrl.sv
// auth_ctrl: multi-byte key authorization of the power path with link heartbeat timeout.
// Define AUTH_LOCKOUT_EN to build the brute-force fail counter and LOCKOUT state.
module auth_ctrl
  import auth_pkg::*;
#(
  parameter int                   KEY_LEN     = 3,
  parameter logic [8*KEY_LEN-1:0] KEY         = 24'h313247,
  parameter logic [7:0]           GO_CODE     = ASCII_G,
  parameter logic [7:0]           STOP_CODE   = ASCII_S,
  parameter int                   TIMEOUT_CYC = 50_000_000,
  parameter int                   MAX_FAIL    = 3,
  parameter int                   LOCK_CYC    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       rider_off,
  output logic       clr_rdy,
  output logic       pwr_up,
  output logic       locked,
  output logic [2:0] state_o
);
  localparam int IW = $clog2(KEY_LEN + 1);
`ifdef AUTH_LOCKOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC > LOCK_CYC ? TIMEOUT_CYC : LOCK_CYC);
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_q, fail_d;
  logic          locked_q;
`else
  localparam int TW = $clog2(TIMEOUT_CYC) + 0 * (MAX_FAIL + LOCK_CYC);
`endif
  auth_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_val;
  logic          tmr_load, tmr_zero, pwr_up_q, last;
  logic [7:0]    key_b;
  assign clr_rdy = rx_rdy & ~rst;
  assign key_b   = 8'(KEY >> {idx_q, 3'b000});
  assign last    = idx_q == IW'(KEY_LEN - 1);
  auth_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = TW'(TIMEOUT_CYC - 1);
`ifdef AUTH_LOCKOUT_EN
    fail_d   = fail_q;
`endif
    case (state_q)
      IDLE: if (rx_rdy && rx_data == KEY[7:0]) begin
        state_d  = KEY_LEN == 1 ? CONNECTED : auth_pkg::KEY;
        idx_d    = KEY_LEN == 1 ? '0 : IW'(1);
        tmr_load = 1'b1;
`ifdef AUTH_LOCKOUT_EN
        fail_d   = KEY_LEN == 1 ? '0 : fail_q;
`endif
      end
      auth_pkg::KEY: if (rx_rdy) begin
        tmr_load = 1'b1;
        if (rx_data == key_b) begin
          state_d = last ? CONNECTED : auth_pkg::KEY;
          idx_d   = last ? '0 : idx_q + 1'b1;
`ifdef AUTH_LOCKOUT_EN
          fail_d  = last ? '0 : fail_q;
`endif
        end else begin
          idx_d   = '0;
`ifdef AUTH_LOCKOUT_EN
          fail_d  = fail_q == FW'(MAX_FAIL) ? fail_q : fail_q + 1'b1;
          state_d = fail_d == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end else if (tmr_zero) begin
        state_d = IDLE;
        idx_d   = '0;
      end
      CONNECTED: begin
        tmr_load = rx_rdy;
        if ((rx_rdy && rx_data == STOP_CODE) || (!rx_rdy && tmr_zero))
          state_d = rider_off ? IDLE : DISCONNECTED;
      end
      DISCONNECTED: if (rider_off) state_d = IDLE;
        else if (rx_rdy && rx_data == GO_CODE) begin
          state_d  = CONNECTED;
          tmr_load = 1'b1;
        end
`ifdef AUTH_LOCKOUT_EN
      LOCKOUT: if (tmr_zero) begin
        state_d = IDLE;
        fail_d  = '0;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef AUTH_LOCKOUT_EN
    tmr_val = state_d == LOCKOUT ? TW'(LOCK_CYC - 1) : tmr_val;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pwr_up_q <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      fail_q   <= '0;
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pwr_up_q <= state_d == CONNECTED || state_d == DISCONNECTED;
`ifdef AUTH_LOCKOUT_EN
      fail_q   <= fail_d;
      locked_q <= state_d == LOCKOUT;
`endif
    end
  assign pwr_up  = pwr_up_q;
  assign state_o = state_q;
`ifdef AUTH_LOCKOUT_EN
  assign locked  = locked_q;
`else
  assign locked  = 1'b0;
`endif
endmodule

// File: tb/tb_auth_ctrl.sv
// tb_auth_ctrl: directed scenarios plus randomized traffic against a deadline-based reference model.
module tb_auth_ctrl;
  localparam int TO = 16;
  localparam int LK = 32;
  localparam int MF = 3;
  logic clk = 1'b0, rst = 1'b1, rx_rdy = 1'b0, rider_off = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic clr_rdy, pwr_up, locked;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
  logic [7:0] key [3] = '{8'h47, 8'h32, 8'h31};
  int m_st, m_pos, m_fails;
  longint cyc, zero_at;
  logic clr_seen;
  auth_ctrl #(
    .KEY_LEN(3), .KEY(24'h313247), .GO_CODE(8'h47), .STOP_CODE(8'h53),
    .TIMEOUT_CYC(TO), .MAX_FAIL(MF), .LOCK_CYC(LK)
  ) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rider_off(rider_off),
    .clr_rdy(clr_rdy), .pwr_up(pwr_up), .locked(locked), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic model_init();
    m_st = 0; m_pos = 0; m_fails = 0; cyc = 0; zero_at = 0;
  endtask
  // One clock cycle of stimulus; the model tracks timer deadlines as absolute edge numbers.
  task automatic cycle(input logic r, input logic [7:0] d, input logic o);
    bit z;
    rx_rdy = r; rx_data = d; rider_off = o;
    @(negedge clk);
    clr_seen = clr_rdy;
    z = cyc >= zero_at;
    case (m_st)
      0: if (r && d == key[0]) begin m_st = 1; m_pos = 1; zero_at = cyc + TO; end
      1: if (r) begin
        zero_at = cyc + TO;
        if (d == key[m_pos]) begin
          m_pos++;
          if (m_pos == 3) begin m_st = 2; m_pos = 0; m_fails = 0; end
        end else begin
          m_pos = 0; m_st = 0;
`ifdef AUTH_LOCKOUT_EN
          m_fails++;
          if (m_fails == MF) begin m_st = 4; zero_at = cyc + LK; end
`endif
        end
      end else if (z) begin m_st = 0; m_pos = 0; end
      2: begin
        if (r) zero_at = cyc + TO;
        if ((r && d == 8'h53) || (!r && z)) m_st = o ? 0 : 3;
      end
      3: if (o) m_st = 0; else if (r && d == 8'h47) begin m_st = 2; zero_at = cyc + TO; end
      4: if (z) begin m_st = 0; m_fails = 0; end
      default: m_st = 0;
    endcase
    @(posedge clk); #1;
    cyc++;
  endtask
  task automatic send_key();
    for (int i = 0; i < 3; i++) cycle(1'b1, key[i], 1'b0);
  endtask
  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'h47;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (clr_rdy !== 1'b0) begin errors++; $display("FAIL reset_clr: clr_rdy=%b want 0", clr_rdy); end
    checks++;
    if (state_o !== 3'd0 || pwr_up !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%0d pwr=%b lock=%b want 0/0/0", state_o, pwr_up, locked);
    end
    rst = 1'b0; rx_rdy = 1'b0;
    model_init();
  endtask
  task automatic test_key_entry();
    cycle(1'b1, 8'h47, 1'b0);
    checks++;
    if (clr_seen !== 1'b1 || state_o !== 3'd1 || pwr_up !== 1'b0) begin
      errors++; $display("FAIL key_b0: clr=%b state=%0d pwr=%b want 1/1/0", clr_seen, state_o, pwr_up);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (clr_seen !== 1'b0) begin errors++; $display("FAIL clr_single: clr=%b want 0", clr_seen); end
    cycle(1'b1, 8'h32, 1'b0);
    checks++;
    if (clr_seen !== 1'b1 || state_o !== 3'd1 || pwr_up !== 1'b0) begin
      errors++; $display("FAIL key_b1: clr=%b state=%0d pwr=%b want 1/1/0", clr_seen, state_o, pwr_up);
    end
    cycle(1'b1, 8'h31, 1'b0);
    checks++;
    if (state_o !== 3'd2 || pwr_up !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL key_done: state=%0d pwr=%b lock=%b want 2/1/0", state_o, pwr_up, locked);
    end
  endtask
  task automatic test_heartbeat();
    repeat (15) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL hb_early: state=%0d want 2", state_o); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd3 || pwr_up !== 1'b1) begin
      errors++; $display("FAIL hb_timeout: state=%0d pwr=%b want 3/1", state_o, pwr_up);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (state_o !== 3'd0 || pwr_up !== 1'b0) begin
      errors++; $display("FAIL hb_off: state=%0d pwr=%b want 0/0", state_o, pwr_up);
    end
  endtask
  task automatic test_stop_go();
    send_key();
    cycle(1'b1, 8'h53, 1'b0);
    checks++;
    if (state_o !== 3'd3 || pwr_up !== 1'b1) begin
      errors++; $display("FAIL stop: state=%0d pwr=%b want 3/1", state_o, pwr_up);
    end
    cycle(1'b1, 8'h47, 1'b0);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL go: state=%0d want 2", state_o); end
    cycle(1'b1, 8'h53, 1'b0);
    cycle(1'b1, 8'h47, 1'b1);
    checks++;
    if (state_o !== 3'd0 || pwr_up !== 1'b0) begin
      errors++; $display("FAIL off_priority: state=%0d pwr=%b want 0/0", state_o, pwr_up);
    end
  endtask
  task automatic test_mismatch();
    cycle(1'b1, 8'h47, 1'b0); cycle(1'b1, 8'h32, 1'b0); cycle(1'b1, 8'h99, 1'b0);
    checks++;
    if (state_o !== 3'd0 || pwr_up !== 1'b0) begin
      errors++; $display("FAIL mismatch: state=%0d pwr=%b want 0/0", state_o, pwr_up);
    end
    cycle(1'b1, 8'h47, 1'b0); cycle(1'b1, 8'h47, 1'b0);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL no_recheck: state=%0d want 0", state_o); end
    send_key();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL key_after_fail: state=%0d want 2", state_o); end
    cycle(1'b1, 8'h53, 1'b1);
  endtask
  task automatic test_timeout_edges();
    cycle(1'b1, 8'h47, 1'b0);
    repeat (15) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL key_wait: state=%0d want 1", state_o); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL key_timeout: state=%0d want 0", state_o); end
    send_key();
    repeat (15) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL byte_beats_expiry: state=%0d want 2", state_o); end
    repeat (15) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL reload: state=%0d want 2", state_o); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL reload_expiry: state=%0d want 3", state_o); end
    cycle(1'b0, 8'h00, 1'b1);
  endtask
  task automatic test_lockout();
`ifdef AUTH_LOCKOUT_EN
    repeat (3) begin cycle(1'b1, 8'h47, 1'b0); cycle(1'b1, 8'h99, 1'b0); end
    checks++;
    if (state_o !== 3'd4 || locked !== 1'b1 || pwr_up !== 1'b0) begin
      errors++; $display("FAIL lock_enter: state=%0d lock=%b pwr=%b want 4/1/0", state_o, locked, pwr_up);
    end
    send_key();
    repeat (28) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd4 || locked !== 1'b1) begin
      errors++; $display("FAIL lock_hold: state=%0d lock=%b want 4/1", state_o, locked);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (state_o !== 3'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL lock_exit: state=%0d lock=%b want 0/0", state_o, locked);
    end
`else
    repeat (5) begin cycle(1'b1, 8'h47, 1'b0); cycle(1'b1, 8'h99, 1'b0); end
    checks++;
    if (state_o !== 3'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL no_lock: state=%0d lock=%b want 0/0", state_o, locked);
    end
`endif
    send_key();
    checks++;
    if (state_o !== 3'd2 || pwr_up !== 1'b1) begin
      errors++; $display("FAIL key_after_lock: state=%0d pwr=%b want 2/1", state_o, pwr_up);
    end
    cycle(1'b1, 8'h53, 1'b1);
  endtask
  task automatic test_reset_mid();
    send_key();
    rst = 1'b1; rx_rdy = 1'b1;
    #1;
    checks++;
    if (pwr_up !== 1'b0 || state_o !== 3'd0 || clr_rdy !== 1'b0) begin
      errors++; $display("FAIL async_reset: pwr=%b state=%0d clr=%b want 0/0/0", pwr_up, state_o, clr_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0; rx_rdy = 1'b0;
    model_init();
  endtask
  task automatic test_random();
    logic [7:0] pool [4] = '{8'h47, 8'h32, 8'h31, 8'h53};
    logic r, o;
    logic [7:0] d;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9) < 6;
      o = $urandom_range(0, 11) == 0;
      d = $urandom_range(0, 4) == 4 ? 8'($urandom) : pool[$urandom_range(0, 3)];
      cycle(r, d, o);
      checks++;
      if (clr_seen !== r || state_o !== 3'(m_st) || pwr_up !== (m_st == 2 || m_st == 3) || locked !== (m_st == 4)) begin
        errors++;
        $display("FAIL random[%0d]: clr=%b state=%0d pwr=%b lock=%b want clr=%b state=%0d", i, clr_seen, state_o, pwr_up, locked, r, m_st);
      end
    end
  endtask
  initial begin
    test_reset();
    test_key_entry();
    test_heartbeat();
    test_stop_go();
    test_mismatch();
    test_timeout_edges();
    test_lockout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/auth_ctrl.md
# auth_ctrl

Parametrised rider-authorization controller for the segway power path. Consumes the byte stream of an external UART receiver (rdy/data/clr handshake) and requires a multi-byte key before asserting `pwr_up`. Adds a link heartbeat timeout, single-byte re-authorization after link loss, and an optional brute-force lockout. Sits between the BLE UART receiver and the power/balance enable logic.

## Interface
- `KEY_LEN`, 3: key length in bytes, 1..8.
- `KEY`, 24'h313247: key bytes, sent first-to-last as `KEY[7:0]`, `KEY[15:8]`, … (default sequence 'G','2','1').
- `GO_CODE`, 8'h47: single-byte re-authorization code, valid only in DISCONNECTED.
- `STOP_CODE`, 8'h53: stop request code.
- `TIMEOUT_CYC`, 50_000_000: idle-link cycles before timeout, ≥2.
- `MAX_FAIL`, 3: consecutive key mismatches before lockout, ≥1.
- `LOCK_CYC`, 500_000_000: lockout duration in cycles, ≥2.

Ports:
- `clk` in 1: system clock; the block's only clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_rdy` in 1: a received byte is pending.
- `rx_data` in 8: the pending byte.
- `rider_off` in 1: rider has left the platform.
- `clr_rdy` out 1: consume pulse; combinational, high in any cycle where `rx_rdy`=1 and `rst`=0.
- `pwr_up` out 1: registered power enable.
- `locked` out 1: registered; high in LOCKOUT.
- `state_o` out 3: current state encoding.

## Operation
- Every pending byte is consumed, meaning `clr_rdy`=1 in the same cycle. Consumption is unconditional, in every state.
- States are IDLE, KEY, CONNECTED, DISCONNECTED and LOCKOUT.
- IDLE:
  - byte == `KEY[7:0]` → `idx`=1 and go to KEY. If `KEY_LEN`=1, go to CONNECTED instead.
  - any other byte is discarded and does not count as a failure.
- KEY:
  - byte == key byte `idx` → `idx`+1. On the last key byte, go to CONNECTED and clear `fail_cnt`.
  - mismatch → `fail_cnt`+1 and go to IDLE with `idx`=0. The mismatched byte is not re-checked as a first key byte.
  - timeout → go to IDLE; `fail_cnt` is unchanged.
- CONNECTED:
  - `STOP_CODE` or timeout → IDLE if `rider_off`=1, else DISCONNECTED.
  - any other byte refreshes the timeout.
  - `rider_off` alone causes no transition.
- DISCONNECTED:
  - `rider_off` → IDLE. This has priority over a same-cycle byte, which is consumed and discarded.
  - `GO_CODE` → CONNECTED.
  - other bytes are ignored.
- LOCKOUT:
  - bytes are consumed and discarded.
  - timer expiry → IDLE and clear `fail_cnt`.
- Entry to lockout: a mismatch that makes `fail_cnt` == `MAX_FAIL` goes to LOCKOUT instead of IDLE.
- `pwr_up` is 1 exactly when the registered state is CONNECTED or DISCONNECTED.
- `locked` is 1 exactly when the state is LOCKOUT.
- Widths:
  - `idx` is $clog2(KEY_LEN+1) bits.
  - `fail_cnt` is $clog2(MAX_FAIL+1) bits and saturates.
  - timer is $clog2(max(TIMEOUT_CYC,LOCK_CYC)) bits.

## Timing
- Reset values: state IDLE; `pwr_up`, `locked`, `idx`, `fail_cnt` and timer all 0; `clr_rdy` forced 0 while `rst`=1.
- Reset mid-operation drops `pwr_up` asynchronously.
- A byte consumed in cycle N takes effect at the edge ending cycle N. State, `pwr_up` and `locked` change together one cycle after `rx_rdy` is seen.
- Timer load points:
  - loaded with `TIMEOUT_CYC`-1 on every edge that consumes a byte in KEY or CONNECTED;
  - loaded with the same value on entry to KEY or CONNECTED;
  - loaded with `LOCK_CYC`-1 on entry to LOCKOUT.
- Timer decrements each cycle and holds at 0.
- Expiry is timer == 0 in a cycle with no consumed byte. The transition happens on that edge, exactly `TIMEOUT_CYC` cycles after the last load.
- A byte and expiry in the same cycle: the byte wins and the timer reloads.
- DISCONNECTED does not time out.

## Configuration
- `AUTH_LOCKOUT_EN` defined: the fail counter, the LOCKOUT state and the `locked` output logic are compiled in.
- `AUTH_LOCKOUT_EN` undefined:
  - mismatches always return to IDLE;
  - no fail counter is built, and LOCKOUT is unreachable;
  - `locked` is tied 0;
  - `MAX_FAIL` and `LOCK_CYC` are ignored, and the timer width uses `TIMEOUT_CYC` only.

## Structure
- Package `auth_pkg` holds:
  - `auth_state_t`, 3-bit enum: IDLE=0, KEY=1, CONNECTED=2, DISCONNECTED=3, LOCKOUT=4;
  - ASCII constants `ASCII_G`=8'h47 and `ASCII_S`=8'h53, used as parameter defaults.
- Sub-module `auth_timer`: loadable down-counter.
  - Parameter: `W`.
  - Ports: `clk`, `rst`, `load`, `load_val`, `zero`.
  - One instance serves both the timeout and the lockout.
- The UART receiver stays outside this block.

## Test plan
Benches use `TIMEOUT_CYC`=16 and `LOCK_CYC`=32.

- Key entry:
  - 0x47, 0x32, 0x31 → `pwr_up` rises 1 cycle after the 0x31 `rx_rdy`;
  - each byte gets a single-cycle `clr_rdy`.
- Heartbeat and stop:
  - Connected with no bytes for 16 cycles → DISCONNECTED with `pwr_up`=1.
  - Then `rider_off`=1 → IDLE with `pwr_up`=0.
  - Connected, 0x53 with `rider_off`=0 → DISCONNECTED.
  - Then 0x47 → CONNECTED.
  - A same-cycle 0x47 and `rider_off`=1 → IDLE.
- Mismatch: 0x47, 0x32, 0x99 → IDLE with `pwr_up`=0 and `fail_cnt`=1. A following full key succeeds and clears `fail_cnt`.
- Lockout (with `AUTH_LOCKOUT_EN`):
  - 3 mismatched sequences → `locked`=1;
  - a valid key sent during lockout is ignored;
  - after 32 cycles → IDLE and `locked`=0.
- Lockout compiled out (no `AUTH_LOCKOUT_EN`): 5 mismatches → `locked` stays 0 and the next valid key connects.
- Reset mid-CONNECTED: `rst` pulse → `pwr_up`=0 immediately and state IDLE.
- `rx_rdy` held high during reset → `clr_rdy`=0.
